// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle for the UART transmit scheduler.
// Latency: none, this file is wiring only.
// Backpressure: requests are level-held until ack or err; the transmitter reports progress via tx_busy/tx_done.
interface uart_tx_scheduler_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [11:0] req_cfg;
    logic        tx_busy;
    logic        tx_done;
    logic        enable;
    logic [7:0]  data;
    logic        d_num;
    logic        parity;
    logic        stop_bits;
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  err_id;
    logic        sched_busy;

    // Environment side: requesters plus the UART transmitter.
    modport master (
        output req, req_data, req_cfg, tx_busy, tx_done,
        input  enable, data, d_num, parity, stop_bits, ack, err, err_id, sched_busy
    );

    // Scheduler side.
    modport slave (
        input  req, req_data, req_cfg, tx_busy, tx_done,
        output enable, data, d_num, parity, stop_bits, ack, err, err_id, sched_busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding four requesters' frames to one UART transmitter, with per-transfer timeout.
// Latency: enable two cycles after req; ack one cycle after tx_done; err one cycle after the last allowed wait cycle.
// Backpressure: one frame in flight; other requesters hold req until their ack or err pulse.
module uart_tx_scheduler #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    uart_tx_scheduler_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  gnt, gnt_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic        enable_nxt;
    logic [3:0]  ack_nxt;
    logic        err_nxt;
    logic [1:0]  err_id_nxt;
    logic        load;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;
    logic [7:0]  frame_dat;
    logic [2:0]  frame_cfg;
    logic        timeout;

    // Timeout fires on the last allowed wait cycle; the counter saturates so it stays asserted.
    assign timeout        = (cnt >= (TIMEOUT_CYC - 20'd1));
    assign bus.sched_busy = (state != IDLE);

    // Round-robin search from ptr and selection of the winner's payload/config slice.
    always_comb begin
        pick      = ptr;
        idx       = ptr;
        found     = 1'b0;
        frame_dat = 8'h00;
        frame_cfg = 3'b000;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pick == i[1:0]) begin
                frame_dat = bus.req_data[8*i +: 8];
                frame_cfg = bus.req_cfg[3*i +: 3];
            end
        end
    end

    // Next-state and next-output logic; pulses default low, held outputs default to current value.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        cnt_nxt    = cnt;
        enable_nxt = 1'b0;
        ack_nxt    = 4'b0000;
        err_nxt    = 1'b0;
        err_id_nxt = bus.err_id;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                enable_nxt = 1'b1;
                cnt_nxt    = 20'd0;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (cnt != 20'hF_FFFF) begin
                    cnt_nxt = cnt + 20'd1;
                end
                // tx_done beats a simultaneous timeout so a finished frame is never reported as failed.
                if (bus.tx_done) begin
                    ack_nxt   = 4'b0001 << gnt;
                    state_nxt = ACK;
                end else if (timeout) begin
                    err_nxt    = 1'b1;
                    err_id_nxt = gnt;
                    ptr_nxt    = gnt + 2'd1;
                    state_nxt  = IDLE;
                end else if ((state == WAIT_BUSY) && bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            ACK: begin
                ptr_nxt   = gnt + 2'd1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, round-robin pointer, grant and timeout counter.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            gnt   <= 2'd0;
            cnt   <= 20'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered pulses, abort id, and the frame latched at grant time.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            bus.enable    <= 1'b0;
            bus.ack       <= 4'b0000;
            bus.err       <= 1'b0;
            bus.err_id    <= 2'd0;
            bus.data      <= 8'h00;
            bus.d_num     <= 1'b0;
            bus.parity    <= 1'b0;
            bus.stop_bits <= 1'b0;
        end else begin
            bus.enable <= enable_nxt;
            bus.ack    <= ack_nxt;
            bus.err    <= err_nxt;
            bus.err_id <= err_id_nxt;
            if (load) begin
                bus.data <= frame_dat;
                {bus.stop_bits, bus.parity, bus.d_num} <= frame_cfg;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for the UART transmit scheduler.
// Latency: checks enable/ack/err timing cycle-exactly against hand-derived values.
// Backpressure: emulates the transmitter via tx_busy/tx_done and level-held requests.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [10:0] frame_q[$];
    logic [3:0]  ack_q[$];
    logic [1:0]  err_q[$];
    logic [10:0] exp_fr [4];

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(.TIMEOUT_CYC(20'd16)) dut (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] cur_frame();
        return {bus.data, bus.stop_bits, bus.parity, bus.d_num};
    endfunction

    // Output monitor: every enable, ack and err pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.enable) begin
                check("enable_expected", frame_q.size() > 0, 1);
                if (frame_q.size() > 0) check("frame", cur_frame(), frame_q.pop_front());
            end
            if (bus.ack != 4'b0000) begin
                check("ack_expected", ack_q.size() > 0, 1);
                if (ack_q.size() > 0) check("ack", bus.ack, ack_q.pop_front());
                check("ack_err_excl", bus.err, 0);
            end
            if (bus.err) begin
                check("err_expected", err_q.size() > 0, 1);
                if (err_q.size() > 0) check("err_id", bus.err_id, err_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        bus.req     = 4'b0000;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        while (!bus.enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.enable, 1);
    endtask

    // Transmitter model: busy for busy_n cycles, then a tx_done pulse; returns in the ack cycle.
    task automatic serve(input int busy_n);
        wait_enable("serve_enable");
        repeat (busy_n) begin
            bus.tx_busy = 1'b1;
            @(negedge clk);
        end
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_fr[0] = {8'h0F, 3'b010};
        exp_fr[1] = {8'hA5, 3'b101};
        exp_fr[2] = {8'h5A, 3'b011};
        exp_fr[3] = {8'hC3, 3'b110};
        bus.req      = 4'b0000;
        bus.req_data = 32'hC35A_A50F;
        bus.req_cfg  = {3'b110, 3'b011, 3'b101, 3'b010};
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Reset values.
        check("rst_enable", bus.enable, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_id", bus.err_id, 0);
        check("rst_frame", cur_frame(), 0);
        check("rst_busy", bus.sched_busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Transmitter strobes while idle are ignored.
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        bus.tx_busy = 1'b0;
        @(negedge clk);
        check("idle_ignore_busy", bus.sched_busy, 0);
        check("idle_ignore_ack", bus.ack, 0);

        // Single request with cycle-exact enable and ack latency.
        frame_q.push_back(exp_fr[1]);
        ack_q.push_back(4'b0010);
        bus.req = 4'b0010;
        @(negedge clk);
        check("start_no_enable", bus.enable, 0);
        check("start_sched_busy", bus.sched_busy, 1);
        @(negedge clk);
        check("enable_latency", bus.enable, 1);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ack_before_done", bus.ack, 0);
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("single_ack", bus.ack, 4'b0010);
        check("single_data", bus.data, 8'hA5);
        check("single_cfg", {bus.stop_bits, bus.parity, bus.d_num}, 3'b101);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        check("single_idle", bus.sched_busy, 0);

        // Contention: all four held, round-robin from requester 0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            frame_q.push_back(exp_fr[k % 4]);
            ack_q.push_back(4'b0001 << (k % 4));
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) serve(k % 3);
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);
        check("cont_idle", bus.sched_busy, 0);
        check("cont_acks_drained", ack_q.size(), 0);

        // Timeout on requester 2, then next grant goes to 3.
        do_reset();
        frame_q.push_back(exp_fr[2]);
        err_q.push_back(2'd2);
        bus.req = 4'b0100;
        wait_enable("to_enable");
        bus.tx_busy = 1'b1;
        n = 0;
        while (!bus.err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, 16);
        check("to_err_id", bus.err_id, 2);
        check("to_no_ack", bus.ack, 0);
        check("to_idle", bus.sched_busy, 0);
        bus.tx_busy = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        check("to_err_pulse", bus.err, 0);
        check("to_err_id_hold", bus.err_id, 2);
        frame_q.push_back(exp_fr[3]);
        ack_q.push_back(4'b1000);
        bus.req = 4'b1111;
        serve(1);
        bus.req = 4'b0000;
        @(negedge clk);

        // Collision: tx_done lands on the timeout cycle.
        do_reset();
        frame_q.push_back(exp_fr[0]);
        ack_q.push_back(4'b0001);
        bus.req = 4'b0001;
        wait_enable("col_enable");
        bus.tx_busy = 1'b1;
        repeat (15) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        bus.tx_busy = 1'b0;
        bus.req = 4'b0000;
        check("col_ack", bus.ack, 4'b0001);
        check("col_err", bus.err, 0);
        @(negedge clk);
        check("col_err_late", bus.err, 0);

        // Reset in WAIT_DONE with ptr=2, then restart from requester 0.
        do_reset();
        frame_q.push_back(exp_fr[1]);
        ack_q.push_back(4'b0010);
        bus.req = 4'b0010;
        serve(1);
        bus.req = 4'b0000;
        frame_q.push_back(exp_fr[3]);
        bus.req = 4'b1000;
        wait_enable("rm_enable");
        bus.tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rm_in_flight", bus.sched_busy, 1);
        reset = 1'b1;
        #1;
        check("rm_enable_rst", bus.enable, 0);
        check("rm_ack_rst", bus.ack, 0);
        check("rm_err_rst", bus.err, 0);
        check("rm_frame_rst", cur_frame(), 0);
        check("rm_busy_rst", bus.sched_busy, 0);
        @(negedge clk);
        bus.tx_busy = 1'b0;
        frame_q.push_back(exp_fr[2]);
        ack_q.push_back(4'b0100);
        bus.req = 4'b1100;
        reset = 1'b0;

        // In-flight frame immune to payload, config and request changes.
        wait_enable("dc_enable");
        bus.tx_busy = 1'b1;
        @(negedge clk);
        bus.req_data = 32'h0000_0000;
        bus.req_cfg  = 12'hFFF;
        bus.req      = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check("dc_frame_hold", cur_frame(), exp_fr[2]);
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("dc_ack", bus.ack, 4'b0100);
        check("dc_frame_at_ack", cur_frame(), exp_fr[2]);
        bus.req_data = 32'hC35A_A50F;
        bus.req_cfg  = {3'b110, 3'b011, 3'b101, 3'b010};
        frame_q.push_back(exp_fr[3]);
        ack_q.push_back(4'b1000);
        serve(0);
        bus.req = 4'b0000;

        repeat (3) @(negedge clk);
        check("frame_q_empty", frame_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 20'd1_000_000, giving the clk_50M cycles allowed per transfer before it is aborted.
REQ-002 The block SHALL have port clk_50M, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, one transmit request per requester; level, held until ack or err.
REQ-005 The block SHALL have port req_data, input, 32, the payload; requester i uses bits [8i+7:8i].
REQ-006 The block SHALL have port req_cfg, input, 12, the frame config; requester i uses bits [3i+2:3i] = {stop_bits, parity, d_num}.
REQ-007 The block SHALL have port tx_busy, input, 1, the transmitter's frame-in-progress indicator.
REQ-008 The block SHALL have port tx_done, input, 1, a one-cycle pulse from the transmitter at stop-bit end.
REQ-009 The block SHALL have port enable, output, 1, a one-cycle start pulse to the transmitter.
REQ-010 The block SHALL have ports data (output, 8), d_num (output, 1), parity (output, 1) and stop_bits (output, 1), the latched frame to the transmitter.
REQ-011 The block SHALL have port ack, output, 4, a one-cycle pulse to the granted requester on completion.
REQ-012 The block SHALL have port err, output, 1, a one-cycle pulse on timeout abort.
REQ-013 The block SHALL have port err_id, output, 2, the requester index of the last abort, held until the next abort.
REQ-014 The block SHALL have port sched_busy, output, 1, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE and ACK, encoded in 3 bits.
REQ-016 In IDLE with req!=0, the FSM SHALL select the first set req bit searching ptr, ptr+1, ... modulo 4, store it as gnt and go to START.
REQ-017 In IDLE with req==0, the FSM SHALL stay in IDLE with all outputs unchanged except pulses, which are 0.
REQ-018 On the IDLE->START edge, the block SHALL latch data, d_num, parity and stop_bits from slice gnt and hold them constant until the FSM returns to IDLE.
REQ-019 In START, the block SHALL drive enable=1 for exactly one cycle, clear the timeout counter and go to WAIT_BUSY.
REQ-020 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE, and tx_done=1 SHALL move it directly to ACK.
REQ-021 In WAIT_DONE, tx_done=1 SHALL move the FSM to ACK.
REQ-022 In ACK, the block SHALL drive ack[gnt]=1 for one cycle, set ptr=gnt+1 (2-bit wrap, 3->0) and return to IDLE; ack latency is 1 cycle after the tx_done cycle.
REQ-023 The timeout counter SHALL be 20 bits, increment every cycle in WAIT_BUSY and WAIT_DONE, and saturate.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1 without tx_done, the block SHALL drive err=1 for one cycle, set err_id=gnt and ptr=gnt+1, return to IDLE and issue no ack.
REQ-025 When tx_done and the timeout occur in the same cycle, tx_done SHALL win: ACK is taken and no err is issued.
REQ-026 If req[gnt] drops after the grant, the transfer SHALL complete and ack SHALL still pulse; the requester ignores it.
REQ-027 req, req_data and req_cfg changes after the grant SHALL NOT affect the frame in flight.
REQ-028 tx_done or tx_busy in IDLE or START SHALL be ignored.
REQ-029 At most one ack bit SHALL be high in any cycle, and ack and err SHALL never be high together.
REQ-030 A requester holding req continuously SHALL be re-served no sooner than after every other pending requester has been served once (round-robin fairness).

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, ptr=0, gnt=0, counter=0, enable=0, ack=0, err=0, err_id=0, data=8'h00, d_num=0, parity=0, stop_bits=0, sched_busy=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no ack or err pulse; the first grant after release SHALL search from requester 0.

Verification
REQ-033 Single request: req=4'b0010, slice1=8'hA5, cfg=3'b101 -> data=A5, stop_bits=1, d_num=1, parity=0, with an enable pulse 2 cycles after req; tx_busy then tx_done -> ack=4'b0010 on the next cycle.
REQ-034 Contention: req=4'b1111 held, each transfer completed -> ack order 0,1,2,3,0 with no double grants.
REQ-035 Timeout: TIMEOUT_CYC=16, grant requester 2, tx_busy=1, tx_done never sent -> err pulse after 16 WAIT cycles, err_id=2, ack stays 0, next grant goes to requester 3.
REQ-036 Collision: tx_done in the same cycle as the timeout -> ack pulses and err stays 0.
REQ-037 Reset in WAIT_DONE with ptr=2 -> all outputs at reset values immediately; req=4'b1100 after release -> requester 2 granted.
REQ-038 Data change: req_data is altered in WAIT_DONE -> data output unchanged until IDLE.
